// File: rtl/nts_dispatcher_pkg.sv
// nts_dispatcher_pkg
// Shared encodings for the NTS receive dispatcher:
//   bank_state_e : life cycle of one packet-buffer bank
//   wr_state_e   : MAC-side write FSM states
//   rd_state_e   : engine-side read FSM states
//   MAC_MASK_*   : byte-valid mask constants of the MAC receive path
//   sat_add      : saturating 32-bit counter increment
package nts_dispatcher_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_WRITING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_ACTIVE = 1'b1
  } rd_state_e;

  localparam logic [7:0] MAC_MASK_FULL = 8'hFF;
  localparam logic [7:0] MAC_MASK_NONE = 8'h00;

  // Adds 0..3 to a counter and sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/nts_dispatcher_bank_ram.sv
// nts_dispatcher_bank_ram
// Simple dual-port 64-bit RAM holding both packet banks, addressed {bank, ptr}.
// Read is registered (1-cycle latency); rd_data holds its value while rd_en=0.
// Ports:
//   clk              clock
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr/rd_data   registered read port
module nts_dispatcher_bank_ram #(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [63:0]          wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [63:0]          rd_data
);

  logic [63:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nts_dispatcher_rx.sv
// nts_dispatcher_rx
// Receives MAC frames into a two-bank packet buffer and offers committed
// frames to the NTS engine through a first-word-fall-through read port.
//
// Write FSM
//   state    | meaning
//   WR_IDLE  | waiting for a frame start
//   WR_WRITE | storing words of the open frame into wr_bank
//   WR_DROP  | discarding a frame until its good/bad pulse
// Read FSM
//   state     | meaning
//   RD_IDLE   | no frame selected for the engine
//   RD_ACTIVE | rd_bank presented; head word prefetched from the RAM
//
// Ports:
//   i_clk, i_areset (active-low async)
//   i_mac_rx_*          MAC receive path (start, byte mask, data, good, bad)
//   o/i_dispatch_*      engine side: available, discard, last-word mask,
//                       FWFT fifo (empty, rd_en, rd_data)
//   o_counter_good      frames committed (saturating)
//   o_counter_dropped   frames dropped (saturating)
module nts_dispatcher_rx
  import nts_dispatcher_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_mac_rx_start,
  input  logic [7:0]  i_mac_rx_data_valid,
  input  logic [63:0] i_mac_rx_data,
  input  logic        i_mac_rx_good,
  input  logic        i_mac_rx_bad,
  output logic        o_dispatch_packet_available,
  input  logic        i_dispatch_packet_read_discard,
  output logic [7:0]  o_dispatch_data_valid,
  output logic        o_dispatch_fifo_empty,
  input  logic        i_dispatch_fifo_rd_en,
  output logic [63:0] o_dispatch_fifo_rd_data,
  output logic [31:0] o_counter_good,
  output logic [31:0] o_counter_dropped
);

  localparam logic [ADDR_WIDTH:0] BANK_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);

  bank_state_e         bank_state [2];
  logic [ADDR_WIDTH:0] bank_cnt   [2];
  logic [7:0]          bank_mask  [2];
  logic                older_bank;

  // ---------------------------------------------------------------- write side
  wr_state_e           wr_state, wr_state_nx;
  logic                wr_bank, wr_bank_nx;
  logic [1:0]          set_writing, set_full, set_empty;
  logic                ram_we;
  logic [ADDR_WIDTH:0] ram_waddr;
  logic                cnt_we, cnt_bank;
  logic [ADDR_WIDTH:0] cnt_val;
  logic                inc_good;
  logic [1:0]          inc_drop;
  logic                mac_word, mac_end, new_frame, abort_open;
  logic [1:0]          bank_free;

  assign mac_word = (i_mac_rx_data_valid != MAC_MASK_NONE);
  assign mac_end  = i_mac_rx_good | i_mac_rx_bad;

  always_comb begin
    wr_state_nx = wr_state;
    wr_bank_nx  = wr_bank;
    set_writing = '0;
    set_full    = '0;
    set_empty   = '0;
    ram_we      = 1'b0;
    ram_waddr   = '0;
    cnt_we      = 1'b0;
    cnt_bank    = wr_bank;
    cnt_val     = '0;
    inc_good    = 1'b0;
    inc_drop    = 2'd0;
    new_frame   = 1'b0;
    abort_open  = 1'b0;
    bank_free   = '0;

    case (wr_state)
      WR_IDLE: new_frame = i_mac_rx_start & mac_word;
      WR_WRITE: begin
        if (i_mac_rx_start && mac_word) begin
          // Frame restarted without an end pulse: the open frame is lost.
          abort_open         = 1'b1;
          set_empty[wr_bank] = 1'b1;
          inc_drop           = 2'd1;
          new_frame          = 1'b1;
        end else if (mac_word && bank_cnt[wr_bank] == BANK_WORDS) begin
          set_empty[wr_bank] = 1'b1;
          if (mac_end) begin
            inc_drop    = 2'd1;
            wr_state_nx = WR_IDLE;
          end else begin
            wr_state_nx = WR_DROP;
          end
        end else begin
          if (mac_word) begin
            ram_we    = 1'b1;
            ram_waddr = {wr_bank, bank_cnt[wr_bank][ADDR_WIDTH-1:0]};
            cnt_we    = 1'b1;
            cnt_bank  = wr_bank;
            cnt_val   = bank_cnt[wr_bank] + CNT_ONE;
          end
          if (i_mac_rx_good) begin
            set_full[wr_bank] = 1'b1;
            inc_good          = 1'b1;
            wr_state_nx       = WR_IDLE;
          end else if (i_mac_rx_bad) begin
            set_empty[wr_bank] = 1'b1;
            inc_drop           = 2'd1;
            wr_state_nx        = WR_IDLE;
          end
        end
      end
      WR_DROP: begin
        if (mac_end) begin
          inc_drop    = 2'd1;
          wr_state_nx = WR_IDLE;
        end
      end
      default: wr_state_nx = WR_IDLE;
    endcase

    // A bank being aborted this cycle may be reused by the restarting frame.
    bank_free[0] = (bank_state[0] == BANK_EMPTY) || (abort_open && !wr_bank);
    bank_free[1] = (bank_state[1] == BANK_EMPTY) || (abort_open &&  wr_bank);

    if (new_frame) begin
      if (bank_free != 2'b00) begin
        wr_bank_nx = bank_free[0] ? 1'b0 : 1'b1;
        ram_we     = 1'b1;
        ram_waddr  = {wr_bank_nx, {ADDR_WIDTH{1'b0}}};
        cnt_we     = 1'b1;
        cnt_bank   = wr_bank_nx;
        cnt_val    = CNT_ONE;
        if (i_mac_rx_good) begin
          set_full[wr_bank_nx] = 1'b1;
          inc_good             = 1'b1;
          wr_state_nx          = WR_IDLE;
        end else if (i_mac_rx_bad) begin
          set_empty[wr_bank_nx] = 1'b1;
          inc_drop              = inc_drop + 2'd1;
          wr_state_nx           = WR_IDLE;
        end else begin
          set_writing[wr_bank_nx] = 1'b1;
          wr_state_nx             = WR_WRITE;
        end
      end else if (mac_end) begin
        inc_drop    = inc_drop + 2'd1;
        wr_state_nx = WR_IDLE;
      end else begin
        wr_state_nx = WR_DROP;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      wr_state          <= WR_IDLE;
      wr_bank           <= 1'b0;
      o_counter_good    <= '0;
      o_counter_dropped <= '0;
      for (int b = 0; b < 2; b++) begin
        bank_cnt[b]  <= '0;
        bank_mask[b] <= '0;
      end
    end else begin
      wr_state <= wr_state_nx;
      wr_bank  <= wr_bank_nx;
      if (cnt_we) begin
        bank_cnt[cnt_bank]  <= cnt_val;
        bank_mask[cnt_bank] <= i_mac_rx_data_valid;
      end
      if (inc_good) o_counter_good <= sat_add(o_counter_good, 2'd1);
      if (inc_drop != 2'd0) o_counter_dropped <= sat_add(o_counter_dropped, inc_drop);
    end
  end

  // ----------------------------------------------------------------- read side
  rd_state_e           rd_state;
  logic                rd_bank;
  logic [ADDR_WIDTH:0] rd_count, fetch_ptr;
  logic                head_valid, pend;
  logic [63:0]         head_data, ram_rd_data;
  logic [1:0]          rd_take, rd_release;
  logic                sel_ok, sel_bank, discard, pop, head_free, consume, issue;

  always_comb begin
    rd_take    = '0;
    rd_release = '0;
    sel_ok     = (rd_state == RD_IDLE) &&
                 ((bank_state[0] == BANK_FULL) || (bank_state[1] == BANK_FULL));
    if ((bank_state[0] == BANK_FULL) && (bank_state[1] == BANK_FULL))
      sel_bank = older_bank;
    else
      sel_bank = (bank_state[0] == BANK_FULL) ? 1'b0 : 1'b1;
    if (sel_ok) rd_take[sel_bank] = 1'b1;
    discard = (rd_state == RD_ACTIVE) && i_dispatch_packet_read_discard;
    if (discard) rd_release[rd_bank] = 1'b1;
    // head_data is stage 1, the RAM output register (pend) is stage 2; a read
    // is only issued when stage 2 is free or drains this cycle.
    pop       = (rd_state == RD_ACTIVE) && head_valid && i_dispatch_fifo_rd_en && !discard;
    head_free = !head_valid || pop;
    consume   = pend && head_free;
    issue     = (rd_state == RD_ACTIVE) && !discard && (fetch_ptr != rd_count) &&
                (!pend || consume);
  end

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      rd_state                    <= RD_IDLE;
      rd_bank                     <= 1'b0;
      rd_count                    <= '0;
      fetch_ptr                   <= '0;
      head_valid                  <= 1'b0;
      pend                        <= 1'b0;
      head_data                   <= '0;
      o_dispatch_packet_available <= 1'b0;
      o_dispatch_data_valid       <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (sel_ok) begin
            rd_state                    <= RD_ACTIVE;
            rd_bank                     <= sel_bank;
            rd_count                    <= bank_cnt[sel_bank];
            fetch_ptr                   <= '0;
            head_valid                  <= 1'b0;
            pend                        <= 1'b0;
            o_dispatch_packet_available <= 1'b1;
            o_dispatch_data_valid       <= bank_mask[sel_bank];
          end
        end
        RD_ACTIVE: begin
          if (discard) begin
            rd_state                    <= RD_IDLE;
            head_valid                  <= 1'b0;
            pend                        <= 1'b0;
            o_dispatch_packet_available <= 1'b0;
            o_dispatch_data_valid       <= '0;
          end else begin
            if (head_free) begin
              head_valid <= pend;
              if (pend) head_data <= ram_rd_data;
            end
            pend <= issue || (pend && !consume);
            if (issue) fetch_ptr <= fetch_ptr + CNT_ONE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign o_dispatch_fifo_empty   = !head_valid;
  assign o_dispatch_fifo_rd_data = head_data;

  // ------------------------------------------------------------ bank tracking
  // Write and read events never target the same bank in one cycle; for the
  // write side, commit beats claim beats release (restart may reuse a bank).
  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      for (int b = 0; b < 2; b++) bank_state[b] <= BANK_EMPTY;
      older_bank <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (set_full[b])                       bank_state[b] <= BANK_FULL;
        else if (set_writing[b])               bank_state[b] <= BANK_WRITING;
        else if (set_empty[b] || rd_release[b]) bank_state[b] <= BANK_EMPTY;
        else if (rd_take[b])                   bank_state[b] <= BANK_READING;
      end
      // Remember which FULL bank was committed first.
      if (set_full[0])      older_bank <= (bank_state[1] == BANK_FULL);
      else if (set_full[1]) older_bank <= (bank_state[0] != BANK_FULL);
    end
  end

  nts_dispatcher_bank_ram #(
    .ADDR_BITS(ADDR_WIDTH + 1)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (i_mac_rx_data),
    .rd_en   (issue),
    .rd_addr ({rd_bank, fetch_ptr[ADDR_WIDTH-1:0]}),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_nts_dispatcher_rx.sv
// Directed self-checking bench for nts_dispatcher_rx (ADDR_WIDTH=3, 8 words/bank).
module tb_nts_dispatcher_rx;
  import nts_dispatcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  dvalid = '0;
  logic [63:0] data = '0;
  logic        good = 1'b0;
  logic        bad = 1'b0;
  logic        avail;
  logic        discard = 1'b0;
  logic [7:0]  dv;
  logic        empty;
  logic        rd_en = 1'b0;
  logic [63:0] rd_data;
  logic [31:0] cg, cd;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  nts_dispatcher_rx #(.ADDR_WIDTH(3)) dut (
    .i_clk                          (clk),
    .i_areset                       (rst_n),
    .i_mac_rx_start                 (start),
    .i_mac_rx_data_valid            (dvalid),
    .i_mac_rx_data                  (data),
    .i_mac_rx_good                  (good),
    .i_mac_rx_bad                   (bad),
    .o_dispatch_packet_available    (avail),
    .i_dispatch_packet_read_discard (discard),
    .o_dispatch_data_valid          (dv),
    .o_dispatch_fifo_empty          (empty),
    .i_dispatch_fifo_rd_en          (rd_en),
    .o_dispatch_fifo_rd_data        (rd_data),
    .o_counter_good                 (cg),
    .o_counter_dropped              (cd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [7:0] last_mask, input logic [63:0] base,
                            input bit is_good, input bit end_same);
    for (int i = 0; i < n; i++) begin
      start  = (i == 0);
      dvalid = (i == n - 1) ? last_mask : MAC_MASK_FULL;
      data   = base + 64'(i);
      if (end_same && i == n - 1) begin
        good = is_good;
        bad  = !is_good;
      end
      tick();
    end
    start = 1'b0; dvalid = '0; data = '0;
    if (!end_same) begin
      good = is_good;
      bad  = !is_good;
      tick();
    end
    good = 1'b0; bad = 1'b0;
  endtask

  task automatic wait_avail(output bit ok);
    int k = 0;
    while (avail !== 1'b1 && k < 20) begin tick(); k++; end
    ok = (avail === 1'b1);
  endtask

  task automatic wait_head(input int limit, output bit ok);
    int k = 0;
    while (empty !== 1'b0 && k < limit) begin tick(); k++; end
    ok = (empty === 1'b0);
  endtask

  task automatic pulse_discard();
    discard = 1'b1; tick(); discard = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    n_total++; if (avail !== 1'b0) $display("FAIL rst_avail got=%b exp=0", avail); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", empty); else n_pass++;
    n_total++; if (dv !== 8'h00) $display("FAIL rst_dv got=%h exp=00", dv); else n_pass++;
    n_total++; if (rd_data !== 64'h0) $display("FAIL rst_rd_data got=%h exp=0", rd_data); else n_pass++;
    n_total++; if (cg !== 32'd0) $display("FAIL rst_cg got=%0d exp=0", cg); else n_pass++;
    n_total++; if (cd !== 32'd0) $display("FAIL rst_cd got=%0d exp=0", cd); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok;
    send_frame(3, 8'h0F, 64'h1000, 1'b1, 1'b0);
    wait_avail(ok);
    n_total++; if (!ok) $display("FAIL basic_avail got=%b exp=1", avail); else n_pass++;
    wait_head(2, ok);
    n_total++; if (!ok) $display("FAIL basic_prefetch empty got=%b exp=0 within 2 cycles", empty); else n_pass++;
    n_total++; if (dv !== 8'h0F) $display("FAIL basic_dv got=%h exp=0f", dv); else n_pass++;
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (empty !== 1'b0 || rd_data !== 64'h1000 + 64'(i))
        $display("FAIL basic_pop%0d got=%h empty=%b exp=%h", i, rd_data, empty, 64'h1000 + 64'(i));
      else n_pass++;
      tick();
    end
    rd_en = 1'b0;
    n_total++; if (empty !== 1'b1) $display("FAIL basic_empty_end got=%b exp=1", empty); else n_pass++;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_total++; if (empty !== 1'b1 || avail !== 1'b1) $display("FAIL basic_pop_when_empty empty=%b avail=%b exp=1,1", empty, avail); else n_pass++;
    n_total++; if (cg !== 32'd1) $display("FAIL basic_cg got=%0d exp=1", cg); else n_pass++;
    pulse_discard();
    n_total++; if (avail !== 1'b0 || empty !== 1'b1) $display("FAIL basic_discard avail=%b empty=%b exp=0,1", avail, empty); else n_pass++;
    tick(); tick(); tick();
    n_total++; if (avail !== 1'b0) $display("FAIL basic_no_repeat avail=%b exp=0", avail); else n_pass++;
  endtask

  task automatic test_bad();
    bit ok;
    send_frame(2, 8'hFF, 64'h1500, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    n_total++; if (avail !== 1'b0) $display("FAIL bad_avail got=%b exp=0", avail); else n_pass++;
    n_total++; if (cd !== 32'd1) $display("FAIL bad_cd got=%0d exp=1", cd); else n_pass++;
    send_frame(2, 8'h3C, 64'h2000, 1'b1, 1'b1);
    wait_avail(ok);
    n_total++; if (!ok) $display("FAIL bad_reuse_avail got=%b exp=1", avail); else n_pass++;
    wait_head(2, ok);
    n_total++; if (!ok) $display("FAIL bad_reuse_head empty=%b exp=0", empty); else n_pass++;
    n_total++; if (dv !== 8'h3C) $display("FAIL bad_reuse_dv got=%h exp=3c", dv); else n_pass++;
    rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (empty !== 1'b0 || rd_data !== 64'h2000 + 64'(i))
        $display("FAIL bad_reuse_pop%0d got=%h empty=%b exp=%h", i, rd_data, empty, 64'h2000 + 64'(i));
      else n_pass++;
      tick();
    end
    rd_en = 1'b0;
    n_total++; if (empty !== 1'b1) $display("FAIL bad_reuse_empty got=%b exp=1", empty); else n_pass++;
    n_total++; if (cg !== 32'd2) $display("FAIL bad_reuse_cg got=%0d exp=2", cg); else n_pass++;
    pulse_discard();
  endtask

  task automatic test_overflow();
    bit ok;
    send_frame(9, 8'hFF, 64'h3000, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    n_total++; if (avail !== 1'b0) $display("FAIL ovf_avail got=%b exp=0", avail); else n_pass++;
    n_total++; if (cd !== 32'd2) $display("FAIL ovf_cd got=%0d exp=2", cd); else n_pass++;
    n_total++; if (cg !== 32'd2) $display("FAIL ovf_cg got=%0d exp=2", cg); else n_pass++;
    send_frame(8, 8'h01, 64'h3100, 1'b1, 1'b0);
    wait_avail(ok);
    n_total++; if (!ok) $display("FAIL full8_avail got=%b exp=1", avail); else n_pass++;
    wait_head(2, ok);
    n_total++; if (!ok) $display("FAIL full8_head empty=%b exp=0", empty); else n_pass++;
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (empty !== 1'b0 || rd_data !== 64'h3100 + 64'(i))
        $display("FAIL full8_pop%0d got=%h empty=%b exp=%h", i, rd_data, empty, 64'h3100 + 64'(i));
      else n_pass++;
      tick();
    end
    rd_en = 1'b0;
    n_total++; if (empty !== 1'b1) $display("FAIL full8_empty got=%b exp=1", empty); else n_pass++;
    n_total++; if (cg !== 32'd3) $display("FAIL full8_cg got=%0d exp=3", cg); else n_pass++;
    pulse_discard();
  endtask

  task automatic test_back_to_back();
    bit ok;
    send_frame(2, 8'hFF, 64'hA000, 1'b1, 1'b0);
    send_frame(2, 8'h07, 64'hB000, 1'b1, 1'b0);
    send_frame(2, 8'hFF, 64'hC000, 1'b1, 1'b0);
    tick(); tick();
    n_total++; if (cg !== 32'd5) $display("FAIL b2b_cg got=%0d exp=5", cg); else n_pass++;
    n_total++; if (cd !== 32'd3) $display("FAIL b2b_cd got=%0d exp=3", cd); else n_pass++;
    wait_head(4, ok);
    n_total++; if (!ok || avail !== 1'b1 || rd_data !== 64'hA000) $display("FAIL b2b_head_a got=%h avail=%b exp=a000", rd_data, avail); else n_pass++;
    pulse_discard();
    n_total++; if (avail !== 1'b0) $display("FAIL b2b_gap avail=%b exp=0", avail); else n_pass++;
    wait_avail(ok);
    n_total++; if (!ok) $display("FAIL b2b_avail_b got=%b exp=1", avail); else n_pass++;
    wait_head(2, ok);
    n_total++; if (!ok || rd_data !== 64'hB000 || dv !== 8'h07) $display("FAIL b2b_head_b got=%h dv=%h exp=b000 dv=07", rd_data, dv); else n_pass++;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_total++; if (empty !== 1'b0 || rd_data !== 64'hB001) $display("FAIL b2b_pop_b1 got=%h exp=b001", rd_data); else n_pass++;
    pulse_discard();
    tick(); tick(); tick();
    n_total++; if (avail !== 1'b0) $display("FAIL b2b_c_absent avail=%b exp=0", avail); else n_pass++;
  endtask

  task automatic test_discard_mid();
    bit ok;
    send_frame(4, 8'hFF, 64'h4000, 1'b1, 1'b0);
    wait_avail(ok);
    wait_head(2, ok);
    n_total++; if (!ok || rd_data !== 64'h4000) $display("FAIL mid_head_d0 got=%h exp=4000", rd_data); else n_pass++;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_total++; if (rd_data !== 64'h4001) $display("FAIL mid_head_d1 got=%h exp=4001", rd_data); else n_pass++;
    send_frame(2, 8'h01, 64'h5000, 1'b1, 1'b0);
    pulse_discard();
    n_total++; if (avail !== 1'b0 || empty !== 1'b1) $display("FAIL mid_discard avail=%b empty=%b exp=0,1", avail, empty); else n_pass++;
    wait_avail(ok);
    wait_head(2, ok);
    n_total++; if (!ok || rd_data !== 64'h5000 || dv !== 8'h01) $display("FAIL mid_head_e0 got=%h dv=%h exp=5000 dv=01", rd_data, dv); else n_pass++;
    rd_en = 1'b1; tick();
    n_total++; if (empty !== 1'b0 || rd_data !== 64'h5001) $display("FAIL mid_head_e1 got=%h exp=5001", rd_data); else n_pass++;
    tick(); rd_en = 1'b0;
    n_total++; if (empty !== 1'b1) $display("FAIL mid_empty_e got=%b exp=1", empty); else n_pass++;
    n_total++; if (cg !== 32'd7) $display("FAIL mid_cg got=%0d exp=7", cg); else n_pass++;
    pulse_discard();
  endtask

  task automatic test_reset_mid();
    bit ok;
    start = 1'b1; dvalid = 8'hFF; data = 64'h6000; tick();
    start = 1'b0; data = 64'h6001; tick();
    dvalid = '0; data = '0;
    rst_n = 1'b0; tick();
    n_total++; if (avail !== 1'b0 || empty !== 1'b1 || cg !== 32'd0 || cd !== 32'd0)
      $display("FAIL rstw_outputs avail=%b empty=%b cg=%0d cd=%0d exp=0,1,0,0", avail, empty, cg, cd);
    else n_pass++;
    rst_n = 1'b1; tick();
    send_frame(2, 8'hFF, 64'h7000, 1'b1, 1'b0);
    wait_avail(ok);
    wait_head(2, ok);
    n_total++; if (!ok || rd_data !== 64'h7000 || cg !== 32'd1) $display("FAIL rstw_next got=%h cg=%0d exp=7000 cg=1", rd_data, cg); else n_pass++;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    rst_n = 1'b0; tick();
    n_total++; if (avail !== 1'b0 || empty !== 1'b1 || rd_data !== 64'h0 || cg !== 32'd0 || dv !== 8'h00)
      $display("FAIL rstr_outputs avail=%b empty=%b data=%h cg=%0d dv=%h exp=0,1,0,0,00", avail, empty, rd_data, cg, dv);
    else n_pass++;
    rst_n = 1'b1; tick();
    send_frame(1, 8'h80, 64'h8000, 1'b1, 1'b0);
    wait_avail(ok);
    wait_head(2, ok);
    n_total++; if (!ok || rd_data !== 64'h8000 || dv !== 8'h80) $display("FAIL rstr_next got=%h dv=%h exp=8000 dv=80", rd_data, dv); else n_pass++;
    n_total++; if (cg !== 32'd1 || cd !== 32'd0) $display("FAIL rstr_counters cg=%0d cd=%0d exp=1,0", cg, cd); else n_pass++;
    pulse_discard();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad();
    test_overflow();
    test_back_to_back();
    test_discard_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nts_dispatcher_rx.md
Name: nts_dispatcher_rx

Overview:
Upstream feeder of the NTS engine. Takes 64-bit frames from the Ethernet MAC receive path and stores them in a two-bank packet buffer. Each bank holds one frame and has 2**ADDR_WIDTH words. Only frames the MAC reports as good are committed; each committed frame is then offered to the engine through the dispatch interface (packet_available, first-word-fall-through FIFO read port, read_discard).

Parameters:
ADDR_WIDTH, 10, log2 of words per bank; maximum frame length is 2**ADDR_WIDTH 64-bit words.

Ports:
i_clk  in  1  system clock
i_areset  in  1  asynchronous, active-low reset
i_mac_rx_start  in  1  asserted with the first word of a frame
i_mac_rx_data_valid  in  8  byte-valid mask; 0xFF for a full word, a partial mask on the last word, 0x00 for no word
i_mac_rx_data  in  64  frame word, big-endian byte order
i_mac_rx_good  in  1  one-cycle pulse on or after the last word; frame is OK
i_mac_rx_bad  in  1  one-cycle pulse on or after the last word; frame has CRC or other error
o_dispatch_packet_available  out  1  a committed frame is selected for read
i_dispatch_packet_read_discard  in  1  one-cycle pulse; release the current read frame
o_dispatch_data_valid  out  8  byte mask of the last word of the current read frame
o_dispatch_fifo_empty  out  1  no unread word in the current read frame
i_dispatch_fifo_rd_en  in  1  pop the head word
o_dispatch_fifo_rd_data  out  64  head word, valid while o_dispatch_fifo_empty=0
o_counter_good  out  32  frames committed (saturating)
o_counter_dropped  out  32  frames dropped: bad, overflow or no free bank (saturating)

Behaviour:
- Reset values: all outputs 0, except o_dispatch_fifo_empty=1. Both banks EMPTY, write FSM IDLE, read FSM IDLE.
- Per-bank state is one of EMPTY, WRITING, FULL, READING. Each bank also keeps a word count (ADDR_WIDTH+1 bits) and the last-word byte mask (8 bits).
- Write FSM states: IDLE, WRITE, DROP.
  - IDLE, on start with a non-zero mask: take the lowest-index EMPTY bank, mark it WRITING, store word 0 and go to WRITE. If no bank is EMPTY, go to DROP.
  - WRITE, each non-zero mask: store the word at count, count+1, latch the mask.
  - WRITE, a word arriving when count == 2**ADDR_WIDTH: overflow. The bank goes back to EMPTY and the FSM goes to DROP.
  - WRITE, good pulse: bank becomes FULL, o_counter_good+1, go to IDLE.
  - WRITE, bad pulse: bank becomes EMPTY, o_counter_dropped+1, go to IDLE.
  - DROP: ignore data until a good or bad pulse, then o_counter_dropped+1 and go to IDLE.
  - Good/bad pulse in the same cycle as the last word: store the word first, then apply the pulse.
  - start in WRITE with no preceding good/bad: treat the open frame as bad (count it dropped, free the bank) and begin the new frame in the same cycle.
- Read FSM states: IDLE, ACTIVE.
  - IDLE with a bank FULL: select it (oldest commit first; tie goes to bank 0), mark it READING, set o_dispatch_packet_available=1 on the next cycle.
  - Head prefetch: o_dispatch_fifo_empty falls at most 2 cycles after packet_available rises.
  - Pop rule: rd_en while empty=0 pops the head; the next word is shown on the following cycle with no bubble. When the read pointer reaches count, empty=1.
  - rd_en while empty=1 is ignored.
  - o_dispatch_data_valid shows the last-word mask of the selected bank while available=1.
  - read_discard pulse, any time in ACTIVE (including mid-read): bank becomes EMPTY. available=0 and empty=1 on the next cycle, then return to IDLE.
  - A FULL bank waiting is presented no earlier than 1 cycle after the discard, so available shows a low gap of at least 1 cycle.
  - read_discard in IDLE: ignored.
- Memory: one simple dual-port RAM of 2*2**ADDR_WIDTH x 64, addressed by {bank, ptr}. Read latency 1 cycle, hidden by a one-word skid/prefetch register.
- Counters saturate at 0xFFFFFFFF and never wrap.
- Asserting i_areset mid-frame or mid-read aborts everything immediately. No counter increments for aborted frames.
- A write bank and a read bank are never the same bank.

Decomposition:
- nts_dispatcher_pkg: bank state encodings, write/read FSM state constants, MAC mask constants (full word 0xFF).
- One sub-module, nts_dispatcher_bank_ram: dual-port 64-bit RAM, parameterised by ADDR_WIDTH+1 address bits, with registered read.

Test Plan:
- 3-word frame, masks FF,FF,0F, then good → available=1, 3 pops return words 0..2, data_valid=0x0F, empty=1 after the 3rd pop, discard → available=0, counter_good=1.
- Frame ending with bad → available stays 0, counter_dropped=1, bank reused by the next good frame.
- Frame of 2**ADDR_WIDTH+1 words (ADDR_WIDTH=3: 9 words) then good → dropped, counter_dropped=1, nothing presented.
- Three back-to-back good frames while the engine holds frame A unread → A then B presented in order; C dropped (counter_dropped=1, counter_good=2).
- Discard after 1 of 4 pops → next frame presented with word 0 at head; unread words never appear.
- Reset asserted mid-WRITE and mid-ACTIVE → all outputs at reset values the next cycle; counters 0; the next frame is handled normally.
